// File: rtl/dual_dm.sv
// Dual-port data memory for both CPU pipelines plus a valid/ready loader port.
// Latency: one cycle (registered rdata), write-first on same-address read/write.
// Backpressure: the loader is stalled (ld_ready low) during the clear sweep and whenever either CPU port writes.
// Optional build macro: DM_STATS_EN adds the wr_collision_cnt output.
module dual_dm #(
    parameter int AW             = 9,
    parameter int DW             = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] p0_DM_maddr,
    input  logic [DW-1:0] p0_DM_wdata,
    input  logic          p0_DM_write_mem,
    output logic [DW-1:0] p0_DM_rdata,
    input  logic [AW-1:0] p1_DM_maddr,
    input  logic [DW-1:0] p1_DM_wdata,
    input  logic          p1_DM_write_mem,
    output logic [DW-1:0] p1_DM_rdata,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic          init_busy
`ifdef DM_STATS_EN
    ,
    output logic [15:0]   wr_collision_cnt
`endif
);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int DEPTH = 1 << AW;

    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          clr_we;

    logic [DW-1:0] mem_q [0:DEPTH-1];

    logic [DW-1:0] p0_rdata_q, p0_rdata_d;
    logic [DW-1:0] p1_rdata_q, p1_rdata_d;

    logic          run;
    logic          p0_we;
    logic          p1_we;
    logic          ld_we;
    logic          collision;

    assign run       = (state_q == ST_RUN);
    // A same-address collision drops p0; p1 always lands.
    assign collision = p0_DM_write_mem & p1_DM_write_mem & (p0_DM_maddr == p1_DM_maddr);
    assign p0_we     = run & p0_DM_write_mem & ~collision;
    assign p1_we     = run & p1_DM_write_mem;
    // CPU writes always win over the loader.
    assign ld_ready  = run & ~p0_DM_write_mem & ~p1_DM_write_mem;
    assign ld_we     = ld_valid & ld_ready;

    assign p0_DM_rdata = p0_rdata_q;
    assign p1_DM_rdata = p1_rdata_q;

    // State register and clear-sweep counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: sweep every word once, then serve requests.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clr_we    = 1'b0;
        init_busy = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                init_busy = 1'b1;
                clr_we    = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == {AW{1'b1}}) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Storage array: clear sweep, CPU ports and loader (write enables are mutually resolved above).
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem_q[cnt_q] <= '0;
        end
        if (p0_we) begin
            mem_q[p0_DM_maddr] <= p0_DM_wdata;
        end
        if (p1_we) begin
            mem_q[p1_DM_maddr] <= p1_DM_wdata;
        end
        if (ld_we) begin
            mem_q[ld_addr] <= ld_data;
        end
    end

    // Write-first read: returns whatever this cycle's winning write stores at the address.
    function automatic logic [DW-1:0] read_word(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mem_q[a];
        if (ld_we && (ld_addr == a)) begin
            v = ld_data;
        end
        if (p0_we && (p0_DM_maddr == a)) begin
            v = p0_DM_wdata;
        end
        if (p1_we && (p1_DM_maddr == a)) begin
            v = p1_DM_wdata;
        end
        return v;
    endfunction

    // Read data next-state: zero while clearing, forwarded memory word when running.
    always_comb begin
        p0_rdata_d = '0;
        p1_rdata_d = '0;
        if (run) begin
            p0_rdata_d = read_word(p0_DM_maddr);
            p1_rdata_d = read_word(p1_DM_maddr);
        end
    end

    // Registered read ports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

`ifdef DM_STATS_EN
    logic [15:0] coll_cnt_q;

    assign wr_collision_cnt = coll_cnt_q;

    // Saturating count of same-address dual writes while running.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll_cnt_q <= '0;
        end else if (run && collision && (coll_cnt_q != 16'hFFFF)) begin
            coll_cnt_q <= coll_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dual_dm.sv
// Testbench for dual_dm: directed vectors, a memory-level reference model and a per-cycle compare.
module tb_dual_dm;

    localparam int AW    = 9;
    localparam int DW    = 16;
    localparam int DEPTH = 512;

    logic          clk;
    logic          rst;
    logic [AW-1:0] p0_DM_maddr;
    logic [DW-1:0] p0_DM_wdata;
    logic          p0_DM_write_mem;
    logic [DW-1:0] p0_DM_rdata;
    logic [AW-1:0] p1_DM_maddr;
    logic [DW-1:0] p1_DM_wdata;
    logic          p1_DM_write_mem;
    logic [DW-1:0] p1_DM_rdata;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_data;
    logic          init_busy;
`ifdef DM_STATS_EN
    logic [15:0]   wr_collision_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    dual_dm #(.AW(AW), .DW(DW), .CLEAR_ON_RESET(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .p0_DM_maddr     (p0_DM_maddr),
        .p0_DM_wdata     (p0_DM_wdata),
        .p0_DM_write_mem (p0_DM_write_mem),
        .p0_DM_rdata     (p0_DM_rdata),
        .p1_DM_maddr     (p1_DM_maddr),
        .p1_DM_wdata     (p1_DM_wdata),
        .p1_DM_write_mem (p1_DM_write_mem),
        .p1_DM_rdata     (p1_DM_rdata),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .init_busy       (init_busy)
`ifdef DM_STATS_EN
        ,
        .wr_collision_cnt(wr_collision_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference model: memory is zeroed once 512 sweep cycles have elapsed since reset;
    // afterwards each edge applies p0, then p1 (overriding), then the loader if no CPU write,
    // and each port's next rdata is the memory word after those writes.
    logic [DW-1:0] m_mem [DEPTH];
    int            m_cyc = 0;
    logic [DW-1:0] e_rd0 = '0;
    logic [DW-1:0] e_rd1 = '0;
    logic [15:0]   e_coll = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cyc  = 0;
                e_rd0  = '0;
                e_rd1  = '0;
                e_coll = '0;
            end else if (m_cyc < DEPTH) begin
                m_cyc++;
                e_rd0 = '0;
                e_rd1 = '0;
                if (m_cyc == DEPTH) begin
                    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
                end
            end else begin
                if (p0_DM_write_mem && p1_DM_write_mem && (p0_DM_maddr == p1_DM_maddr)
                    && (e_coll != 16'hFFFF)) e_coll++;
                if (p0_DM_write_mem) m_mem[p0_DM_maddr] = p0_DM_wdata;
                if (p1_DM_write_mem) m_mem[p1_DM_maddr] = p1_DM_wdata;
                if (ld_valid && !p0_DM_write_mem && !p1_DM_write_mem) m_mem[ld_addr] = ld_data;
                e_rd0 = m_mem[p0_DM_maddr];
                e_rd1 = m_mem[p1_DM_maddr];
            end
        end
    end

    // Per-cycle compare, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            check("init_busy", {31'd0, init_busy}, {31'd0, (m_cyc < DEPTH)});
            check("ld_ready", {31'd0, ld_ready},
                  {31'd0, (m_cyc >= DEPTH) && !rst && !p0_DM_write_mem && !p1_DM_write_mem});
            check("p0_rdata", {16'd0, p0_DM_rdata}, {16'd0, e_rd0});
            check("p1_rdata", {16'd0, p1_DM_rdata}, {16'd0, e_rd1});
`ifdef DM_STATS_EN
            check("coll_cnt", {16'd0, wr_collision_cnt}, {16'd0, e_coll});
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_DM_write_mem = 1'b0;
        p1_DM_write_mem = 1'b0;
        ld_valid        = 1'b0;
    endtask

    // Counts negedges with init_busy high, bounded so a stuck sweep still ends.
    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            if (!init_busy) break;
            n++;
        end
        @(posedge clk);
        #1;
    endtask

    int nb;

    initial begin
        rst = 1'b1;
        p0_DM_maddr = '0; p0_DM_wdata = '0; p0_DM_write_mem = 1'b0;
        p1_DM_maddr = '0; p1_DM_wdata = '0; p1_DM_write_mem = 1'b0;
        ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
        step(); step(); step();
        rst = 1'b0;

        // Clear sweep length.
        count_busy(nb);
        check("sweep_len", nb, 32'd512);

        // Cleared word reads zero.
        p0_DM_maddr = 9'h1A5;
        step();
        check("clr_1A5", {16'd0, p0_DM_rdata}, 32'h0000);

        // Basic write then cross-port read.
        p0_DM_maddr = 9'h010; p0_DM_wdata = 16'hBEEF; p0_DM_write_mem = 1'b1;
        step();
        idle();
        p1_DM_maddr = 9'h010;
        step();
        check("basic_rw", {16'd0, p1_DM_rdata}, 32'h0000BEEF);

        // Same-address collision: p1 wins.
        p0_DM_maddr = 9'h055; p0_DM_wdata = 16'h1111; p0_DM_write_mem = 1'b1;
        p1_DM_maddr = 9'h055; p1_DM_wdata = 16'h2222; p1_DM_write_mem = 1'b1;
        step();
        check("coll_fwd_p0", {16'd0, p0_DM_rdata}, 32'h00002222);
        idle();
        p1_DM_maddr = 9'h000;
        step();
        check("coll_read", {16'd0, p0_DM_rdata}, 32'h00002222);
`ifdef DM_STATS_EN
        check("coll_cnt_1", {16'd0, wr_collision_cnt}, 32'd1);
`endif

        // Write-first forwarding across ports.
        p0_DM_maddr = 9'h0F0; p0_DM_wdata = 16'hA5A5; p0_DM_write_mem = 1'b1;
        p1_DM_maddr = 9'h0F0;
        step();
        check("wf_fwd", {16'd0, p1_DM_rdata}, 32'h0000A5A5);
        idle();

        // Loader stalled by three p1 writes, then accepted.
        ld_valid = 1'b1; ld_addr = 9'h020; ld_data = 16'h1234;
        p0_DM_maddr = 9'h020;
        for (int i = 0; i < 3; i++) begin
            p1_DM_maddr = 9'h030 + 9'(i); p1_DM_wdata = 16'h7770 + 16'(i); p1_DM_write_mem = 1'b1;
            #1;
            check("ld_stall", {31'd0, ld_ready}, 32'd0);
            step();
            check("ld_notyet", {16'd0, p0_DM_rdata}, 32'h0000);
        end
        p1_DM_write_mem = 1'b0;
        #1;
        check("ld_accept", {31'd0, ld_ready}, 32'd1);
        step();
        check("ld_fwd", {16'd0, p0_DM_rdata}, 32'h00001234);
        ld_valid = 1'b0;
        p1_DM_maddr = 9'h020;
        step();
        check("ld_read", {16'd0, p1_DM_rdata}, 32'h00001234);

        // Address boundaries.
        p0_DM_maddr = 9'h1FF; p0_DM_wdata = 16'hF00D; p0_DM_write_mem = 1'b1;
        p1_DM_maddr = 9'h000; p1_DM_wdata = 16'h0BAD; p1_DM_write_mem = 1'b1;
        step();
        idle();
        p0_DM_maddr = 9'h000; p1_DM_maddr = 9'h1FF;
        step();
        check("edge_000", {16'd0, p0_DM_rdata}, 32'h00000BAD);
        check("edge_1FF", {16'd0, p1_DM_rdata}, 32'h0000F00D);

        // Reset mid-sweep at cnt = 300; CPU write during the sweep is ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        p0_DM_maddr = 9'h040; p0_DM_wdata = 16'hDEAD; p0_DM_write_mem = 1'b1;
        repeat (300) step();
        idle();
        check("midclr_busy", {31'd0, init_busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        count_busy(nb);
        check("resweep_len", nb, 32'd512);
        p0_DM_maddr = 9'h010; p1_DM_maddr = 9'h040;
        step();
        check("resweep_010", {16'd0, p0_DM_rdata}, 32'h0000);
        check("clr_wr_ign", {16'd0, p1_DM_rdata}, 32'h0000);
`ifdef DM_STATS_EN
        check("coll_cnt_rst", {16'd0, wr_collision_cnt}, 32'd0);
`endif
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dual_dm.md
Name: dual_dm

Overview:
Dual-port 16-bit data memory that responds to both CPU pipeline data-memory ports (p0/p1 maddr, wdata, write_mem, rdata).
- Provides registered one-cycle read latency and deterministic same-cycle write-collision resolution, with pipeline 1 winning over pipeline 0.
- Runs a post-reset clear sweep before serving requests.
- Adds a valid/ready loader port so a testbench or boot block can preload data while the CPU runs.

Parameters:
AW, 9, address width in words (must match CPU maddr width)
DW, 16, data word width
CLEAR_ON_RESET, 1, 1 = zero all 2^AW words after reset; 0 = skip the sweep and enter RUN immediately

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
p0_DM_maddr  input  AW  pipeline 0 word address
p0_DM_wdata  input  DW  pipeline 0 write data
p0_DM_write_mem  input  1  pipeline 0 write enable
p0_DM_rdata  output  DW  pipeline 0 read data (registered)
p1_DM_maddr  input  AW  pipeline 1 word address
p1_DM_wdata  input  DW  pipeline 1 write data
p1_DM_write_mem  input  1  pipeline 1 write enable
p1_DM_rdata  output  DW  pipeline 1 read data (registered)
ld_valid  input  1  loader write request
ld_ready  output  1  loader write accepted this cycle
ld_addr  input  AW  loader word address
ld_data  input  DW  loader write data
init_busy  output  1  high while the clear sweep runs; top level holds the CPU in reset while high

Behaviour:
- Reset (async): p0/p1_DM_rdata = 0, init_busy = CLEAR_ON_RESET, ld_ready = 0, clear counter = 0, state = CLEAR (or RUN if CLEAR_ON_RESET = 0). Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to mem[cnt], then increments cnt.
  - When cnt == 2^AW-1 is written, go to RUN next cycle; init_busy falls in that same cycle.
  - CPU writes and loader writes are ignored; rdata holds 0.
  - Reset asserted mid-sweep restarts at cnt = 0.
- RUN state, reads:
  - rdata_pX is updated every cycle with the content at maddr_pX, visible the next cycle (latency 1).
  - Both ports may read any address simultaneously.
- RUN state, writes:
  - A write happens at the clock edge when write_mem is high.
  - If p0 and p1 write the same address in the same cycle, p1 data is stored and p0 data is dropped.
- RUN state, read/write to the same address in the same cycle (either port, including cross-port): write-first. The registered rdata returns the newly stored value, using the winning (p1) data on collision.
- Loader:
  - ld_ready = RUN & ~p0_DM_write_mem & ~p1_DM_write_mem (combinational).
  - The write occurs when ld_valid & ld_ready. The CPU always has priority; the loader stalls while any CPU write is present.
  - A loader write obeys the same write-first rule for concurrent CPU reads of that address.
- Addresses use the full AW bits with no wrap logic; all 2^AW words are valid.

Optional Feature:
DM_STATS_EN
- Defined:
  - Adds output port wr_collision_cnt (16 bits), reset to 0.
  - Increments by 1 each RUN cycle in which p0 and p1 both write the same address.
  - Saturates at 16'hFFFF. Clears on reset and does not count during CLEAR.
- Undefined: the port and counter do not exist; behaviour is otherwise identical.

Test Plan:
- Clear sweep: pulse rst, CLEAR_ON_RESET = 1 -> init_busy high for exactly 512 cycles, then low; reading addr 0x1A5 returns 0x0000.
- Basic R/W: p0 writes 0xBEEF at 0x010; the next cycle p1 reads 0x010 -> p1_DM_rdata = 0xBEEF one cycle after the address is presented.
- Collision: p0 writes 0x1111 and p1 writes 0x2222 to 0x055 in the same cycle -> a later read returns 0x2222; wr_collision_cnt = 1 with DM_STATS_EN.
- Write-first forward: p0 writes 0xA5A5 to 0x0F0 while p1 reads 0x0F0 in the same cycle -> p1_DM_rdata = 0xA5A5 next cycle.
- Loader stall: hold ld_valid with ld_addr 0x020 / ld_data 0x1234 while p1 writes for 3 cycles -> ld_ready = 0 for those 3 cycles, then 1; a read of 0x020 afterwards returns 0x1234.
- Reset mid-clear: assert rst at cnt = 300 -> the sweep restarts and init_busy stays high for a further 512 cycles after reset release.
